// File: rtl/des_decrypt_key_sequencer.sv
// DES decryption subkey sequencer: streams K16..K1 over a valid/ready handshake,
// regenerating each round key by right-rotating C/D instead of storing all sixteen.
module des_decrypt_key_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key,
  input  logic        start,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, EMIT} state_t;

  // FIPS 46-3 tables, entries are 1-based bit numbers with bit 1 = MSB
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    end
    return r;
  endfunction

  // Reverse of the encryption left-shift schedule: single step at K16, K9 and K2 boundaries
  function automatic logic single_step(input logic [3:0] i);
    return (i == 4'd15) || (i == 4'd8) || (i == 4'd1);
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic one);
    return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
  endfunction

  state_t      state, state_nxt;
  logic [27:0] c, d, c_nxt, d_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        busy_nxt, done_nxt;
  logic [55:0] pc1_key;

  assign pc1_key   = pc1(key);
  assign rk_valid  = (state == EMIT);
  assign round_key = pc2({c, d});
  assign round_idx = idx;

  always_comb begin
    state_nxt = state;
    c_nxt     = c;
    d_nxt     = d;
    idx_nxt   = idx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Total rotation over all rounds is 28, so C16/D16 equal C0/D0
        if (start) begin
          c_nxt     = pc1_key[55:28];
          d_nxt     = pc1_key[27:0];
          idx_nxt   = 4'd15;
          busy_nxt  = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx != 4'd0) begin
            c_nxt   = rotr(c, single_step(idx));
            d_nxt   = rotr(d, single_step(idx));
            idx_nxt = idx - 4'd1;
          end else begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      c     <= c_nxt;
      d     <= d_nxt;
      idx   <= idx_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_des_decrypt_key_sequencer.sv
// Bench for des_decrypt_key_sequencer: reference keys come from a forward
// (encryption-order) key schedule model, compared in reverse order.
module tb_des_decrypt_key_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key;
  logic        start;
  logic [47:0] round_key;
  logic [3:0]  round_idx;
  logic        rk_valid;
  logic        rk_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  des_decrypt_key_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .start     (start),
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy),
    .done      (done)
  );

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int total = 0;
  int bad   = 0;
  logic [47:0] exp_rk [16];   // exp_rk[i] = K(i+1)

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Forward key schedule on bit arrays: element 0 = FIPS bit 1
  function automatic void build_model(input logic [63:0] k);
    bit kb [64];
    bit c [28];
    bit d [28];
    bit t;
    bit cd [56];
    logic [47:0] rk;
    for (int i = 0; i < 64; i++) kb[i] = k[63 - i];
    for (int i = 0; i < 28; i++) begin
      c[i] = kb[PC1[i] - 1];
      d[i] = kb[PC1[i + 28] - 1];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        t = c[0];
        for (int i = 0; i < 27; i++) c[i] = c[i + 1];
        c[27] = t;
        t = d[0];
        for (int i = 0; i < 27; i++) d[i] = d[i + 1];
        d[27] = t;
      end
      for (int i = 0; i < 28; i++) begin
        cd[i]      = c[i];
        cd[i + 28] = d[i];
      end
      rk = '0;
      for (int j = 0; j < 48; j++) rk[47 - j] = cd[PC2[j] - 1];
      exp_rk[r] = rk;
    end
  endfunction

  // One full sequence with random ready duty; optionally pokes start/key at poke_idx
  task automatic run_seq(input logic [63:0] k, input int duty, input int poke_idx);
    int          exp_idx;
    int          xfers;
    bit          stalled;
    bit          fin;
    logic [47:0] prev_rk;
    logic [3:0]  prev_idx;
    build_model(k);
    @(negedge clk);
    key      = k;
    start    = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    key     = {$urandom, $urandom};
    exp_idx = 15;
    xfers   = 0;
    stalled = 1'b0;
    fin     = 1'b0;
    prev_rk = '0;
    prev_idx = '0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      chk("valid", 64'(rk_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("done_low", 64'(done), 64'd0);
      chk("idx", 64'(round_idx), 64'(exp_idx));
      chk("rk", 64'(round_key), 64'(exp_rk[exp_idx]));
      if (stalled) begin
        chk("hold_rk", 64'(round_key), 64'(prev_rk));
        chk("hold_idx", 64'(round_idx), 64'(prev_idx));
      end
      if (exp_idx == poke_idx) begin
        start = 1'b1;
        key   = ~k;
      end
      rk_ready = ($urandom_range(99) < duty);
      prev_rk  = round_key;
      prev_idx = round_idx;
      stalled  = !rk_ready;
      if (rk_ready) begin
        xfers++;
        if (exp_idx == 0) fin = 1'b1;
        else exp_idx--;
      end
      @(negedge clk);
      start = 1'b0;
    end
    if (!fin) chk("timeout", 64'd0, 64'd1);
    rk_ready = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_fall", 64'(busy), 64'd0);
    chk("valid_drop", 64'(rk_valid), 64'd0);
    @(negedge clk);
    chk("done_once", 64'(done), 64'd0);
    chk("valid_idle", 64'(rk_valid), 64'd0);
    chk("xfers", 64'(xfers), 64'd16);
  endtask

  initial begin
    rst_n    = 1'b0;
    key      = '0;
    start    = 1'b0;
    rk_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(rk_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rk", 64'(round_key), 64'd0);
    chk("rst_idx", 64'(round_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known FIPS example key, plus start held through the final acceptance
    @(negedge clk);
    key      = 64'h133457799BBCDFF1;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("k16_idx", 64'(round_idx), 64'd15);
    chk("k16", 64'(round_key), 64'hCB3D8B0E17F5);
    @(negedge clk);
    chk("k15_idx", 64'(round_idx), 64'd14);
    chk("k15", 64'(round_key), 64'hBF918D3D3F0A);
    for (int i = 0; i < 20 && round_idx != 4'd0; i++) @(negedge clk);
    chk("k1_idx", 64'(round_idx), 64'd0);
    chk("k1", 64'(round_key), 64'h1B02EFFC7072);
    start = 1'b1;
    @(negedge clk);
    chk("done_edge_start_ignored", 64'(rk_valid), 64'd0);
    chk("done_edge_pulse", 64'(done), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid", 64'(rk_valid), 64'd1);
    chk("restart_idx", 64'(round_idx), 64'd15);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(64'h133457799BBCDFF1, 100, -1);
    run_seq(64'h133457799BBCDFF1, 50, -1);
    run_seq({$urandom, $urandom}, 50, 9);
    run_seq({$urandom, $urandom}, 30, -1);

    // Asynchronous reset in the middle of a sequence
    @(negedge clk);
    key      = {$urandom, $urandom};
    start    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && round_idx != 4'd7; i++) @(negedge clk);
    chk("pre_rst_idx", 64'(round_idx), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rk_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rk", 64'(round_key), 64'd0);
    chk("mid_rst_idx", 64'(round_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(64'h0, 100, -1);
    run_seq(64'hFFFFFFFFFFFFFFFF, 60, -1);
    chk("ones_model_k8", 64'(exp_rk[7]), 64'hFFFFFFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_decrypt_key_sequencer.md
Name: des_decrypt_key_sequencer

Overview:
- Decryption-side counterpart of the combinational encryption subkey generator.
- Takes a 64-bit DES key and streams the 16 round keys in reverse order (K16 first, K1 last), one per accepted handshake.
- Regenerates each key by right-rotating C/D instead of storing all 16.
- Feeds the sequential decrypt round engine; one 48-bit round key per round.

Parameters:
- none; DES widths are fixed (key 64, C/D 28 each, round key 48).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key  in  64  DES key. key[63] = FIPS 46-3 bit 1; key[0] = bit 64; parity bits ignored.
- start  in  1  load key and begin a sequence; sampled only in IDLE.
- round_key  out  48  current round key. [47] = FIPS K bit 1.
- round_idx  out  4  zero-based index of round_key (15 = K16 ... 0 = K1).
- rk_valid  out  1  round_key/round_idx valid.
- rk_ready  in  1  consumer accepts round_key this cycle.
- busy  out  1  high from the start-accept cycle until the last key is accepted.
- done  out  1  one-cycle pulse after K1 is accepted.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; C, D, idx, round_key, round_idx all zero; rk_valid=0, busy=0, done=0.
  - Deassertion is synchronous to clk by upstream convention.
- States:
  - IDLE: on start=1 at a rising edge: C <= PC-1 left 28 bits of key, D <= PC-1 right 28 bits (C16=C0, since total rotation is 28); idx <= 15; busy <= 1; go to EMIT. start=0 keeps IDLE.
  - EMIT: rk_valid=1; round_key = PC-2({C,D}) (combinational from registers); round_idx = idx.
    - On rk_valid & rk_ready:
      - idx != 0: rotate C and D right by r(idx); idx <= idx-1; stay in EMIT.
      - idx == 0: go to IDLE; busy <= 0; done <= 1 for exactly one cycle; rk_valid drops the next cycle.
- Rotation schedule r(idx): 1 when idx ∈ {15, 8, 1}, else 2. This is the inverse of the encryption left-shift schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Right rotate by n on a 28-bit value: {v[n-1:0], v[27:n]}, with MSB = FIPS bit 1.
- Latency: start accepted at edge t → first key (idx 15) valid after edge t (cycle t+1). With rk_ready tied high, 16 keys arrive on 16 consecutive cycles and done pulses on the cycle after the last key.
- Handshake rules:
  - While rk_valid=1 and rk_ready=0, round_key and round_idx hold stable.
  - rk_valid never drops without acceptance except on reset.
- start while busy (EMIT) is ignored; key changes during EMIT have no effect.
- start on the same edge that done is asserted is ignored, because state is not IDLE at that edge. start is accepted on the following edge if still high.
- Reset mid-sequence: immediate return to IDLE and all outputs zero. The next start restarts from idx 15.
- PC-1 / PC-2 tables are exactly FIPS 46-3, applied MSB-first per the bit convention above.

Test Plan:
- Reset then start with key=64'h133457799BBCDFF1, rk_ready=1 → first key round_idx=15, round_key=48'hCB3D8B0E17F5; next round_idx=14, 48'hBF918D3D3F0A.
- Same key, full run → last key round_idx=0, round_key=48'h1B02EFFC7072; done pulses one cycle later; busy falls with it; exactly 16 valid transfers.
- rk_ready random 50% duty → round_key/round_idx stable while stalled; the accepted sequence matches the stall-free run; done is still a single pulse.
- Pulse start at idx 9 with a different key → ignored; sequence completes with the original key's values.
- Assert rst_n=0 at idx 7 → rk_valid, busy, round_key go 0 asynchronously. Restart with key=64'h0 → all 16 round keys are 48'h0.
- Key=64'hFFFFFFFFFFFFFFFF → all 16 round keys are 48'hFFFFFFFFFFFF. Verify with a reference model that rotation counts sum to 28 (C after idx 0 rotation equals C0 left-rotated by 1).
